// File: rtl/sent_tx_frame_builder.sv
// SENT TX frame builder: captures the fast-channel payload, computes the J2716 CRC and
// streams status, data and CRC nibbles. Define SENT_TX_CRC_RECOMMENDED_EN for the 2010 CRC.
module sent_tx_frame_builder #(
    parameter logic [3:0] CRC_SEED = 4'h5
) (
    input  logic        clk_tx,
    input  logic        reset_n_tx,
    input  logic [2:0]  load_bit_i,
    input  logic [15:0] data_f1_i,
    input  logic [11:0] data_f2_i,
    input  logic        done_pre_data_i,
    input  logic [3:0]  status_nibble_i,
    output logic [3:0]  nibble_o,
    output logic        nibble_valid_o,
    input  logic        nibble_ready_i,
    output logic        frame_start_o,
    output logic        frame_last_o,
    output logic        busy_o,
    output logic        frame_drop_o,
    output logic [2:0]  fsm_state_o
);

    // Handshake: a nibble transfers on every clk_tx edge with nibble_valid_o && nibble_ready_i;
    // while valid && !ready the nibble, frame_start_o and frame_last_o hold, and valid never
    // drops between the status nibble and the CRC nibble.

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CALC        = 3'd1,
        SEND_STATUS = 3'd2,
        SEND_DATA   = 3'd3,
        SEND_CRC    = 3'd4
    } state_t;

`ifdef SENT_TX_CRC_RECOMMENDED_EN
    localparam logic [2:0] AUG_STEPS = 3'd1;
`else
    localparam logic [2:0] AUG_STEPS = 3'd0;
`endif

    state_t      state_q, state_d;
    logic [23:0] word_q, word_d;
    logic [3:0]  status_q, status_d;
    logic        six_q, six_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  crc_q, crc_d;
    logic        drop_q, drop_d;

    logic [2:0]  nib_count;
    logic [2:0]  calc_steps;
    logic [3:0]  cur_nib;
    logic        payload_pulse;
    logic        accept;

    function automatic logic [23:0] pack_word(input logic [2:0]  fmt,
                                              input logic [15:0] f1,
                                              input logic [11:0] f2);
        logic [23:0] w;
        case (fmt)
            3'b001:  w = {f1[11:0], f2[3:0], f2[7:4], f2[11:8]};
            3'b110:  w = {f1[13:0], f2[9:0]};
            3'b111:  w = {f1, f2[7:0]};
            default: w = {f1[11:0], 12'h000};
        endcase
        return w;
    endfunction

    // One CRC step: multiply by x^4 modulo x^4+x^3+x^2+1.
    function automatic logic [3:0] crc_mul(input logic [3:0] c);
        logic [3:0] t;
        case (c)
            4'h0: t = 4'h0;
            4'h1: t = 4'hD;
            4'h2: t = 4'h7;
            4'h3: t = 4'hA;
            4'h4: t = 4'hE;
            4'h5: t = 4'h3;
            4'h6: t = 4'h9;
            4'h7: t = 4'h4;
            4'h8: t = 4'h1;
            4'h9: t = 4'hC;
            4'hA: t = 4'h6;
            4'hB: t = 4'hB;
            4'hC: t = 4'hF;
            4'hD: t = 4'h2;
            4'hE: t = 4'h8;
            default: t = 4'h5;
        endcase
        return t;
    endfunction

    assign nib_count  = six_q ? 3'd6 : 3'd3;
    assign calc_steps = nib_count + AUG_STEPS;

    // Nibble cnt_q of the captured word, MSN first; zero past the last data nibble (augmentation).
    always_comb begin
        cur_nib = 4'h0;
        if (cnt_q < nib_count) begin
            case (cnt_q)
                3'd0:    cur_nib = word_q[23:20];
                3'd1:    cur_nib = word_q[19:16];
                3'd2:    cur_nib = word_q[15:12];
                3'd3:    cur_nib = word_q[11:8];
                3'd4:    cur_nib = word_q[7:4];
                3'd5:    cur_nib = word_q[3:0];
                default: cur_nib = 4'h0;
            endcase
        end
    end

    assign payload_pulse = done_pre_data_i && (load_bit_i != 3'b000);
    assign accept = payload_pulse &&
                    ((state_q == IDLE) || ((state_q == SEND_CRC) && nibble_ready_i));

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        status_d       = status_q;
        six_d          = six_q;
        cnt_d          = cnt_q;
        crc_d          = crc_q;
        drop_d         = 1'b0;
        nibble_o       = 4'h0;
        nibble_valid_o = 1'b0;
        frame_start_o  = 1'b0;
        frame_last_o   = 1'b0;

        case (state_q)
            IDLE: begin
            end
            CALC: begin
                // The cycle after the last CRC step lets the result settle before it is sent.
                if (cnt_q == calc_steps) begin
                    state_d = SEND_STATUS;
                    cnt_d   = 3'd0;
                end else begin
                    crc_d = crc_mul(crc_q) ^ cur_nib;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            SEND_STATUS: begin
                nibble_o       = status_q;
                nibble_valid_o = 1'b1;
                frame_start_o  = 1'b1;
                if (nibble_ready_i) begin
                    state_d = SEND_DATA;
                    cnt_d   = 3'd0;
                end
            end
            SEND_DATA: begin
                nibble_o       = cur_nib;
                nibble_valid_o = 1'b1;
                if (nibble_ready_i) begin
                    if (cnt_q == nib_count - 3'd1) begin
                        state_d = SEND_CRC;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            SEND_CRC: begin
                nibble_o       = crc_q;
                nibble_valid_o = 1'b1;
                frame_last_o   = 1'b1;
                if (nibble_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d  = CALC;
            cnt_d    = 3'd0;
            crc_d    = CRC_SEED;
            word_d   = pack_word(load_bit_i, data_f1_i, data_f2_i);
            status_d = status_nibble_i;
            six_d    = (load_bit_i == 3'b001) || (load_bit_i >= 3'b110);
        end else if (payload_pulse && (state_q != IDLE)) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state_q  <= IDLE;
            word_q   <= 24'h000000;
            status_q <= 4'h0;
            six_q    <= 1'b0;
            cnt_q    <= 3'd0;
            crc_q    <= CRC_SEED;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            status_q <= status_d;
            six_q    <= six_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            drop_q   <= drop_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign frame_drop_o = drop_q;
    assign fsm_state_o  = state_q;

endmodule

// File: tb/tb_sent_tx_frame_builder.sv
// Self-checking bench for sent_tx_frame_builder: randomized payloads, a nibble-level
// reference model with a polynomial-arithmetic CRC, and a decoupled output monitor.
module tb_sent_tx_frame_builder;

    logic        clk_tx;
    logic        reset_n_tx;
    logic [2:0]  load_bit_i;
    logic [15:0] data_f1_i;
    logic [11:0] data_f2_i;
    logic        done_pre_data_i;
    logic [3:0]  status_nibble_i;
    logic [3:0]  nibble_o;
    logic        nibble_valid_o;
    logic        nibble_ready_i;
    logic        frame_start_o;
    logic        frame_last_o;
    logic        busy_o;
    logic        frame_drop_o;
    logic [2:0]  fsm_state_o;

    sent_tx_frame_builder #(.CRC_SEED(4'h5)) dut (
        .clk_tx          (clk_tx),
        .reset_n_tx      (reset_n_tx),
        .load_bit_i      (load_bit_i),
        .data_f1_i       (data_f1_i),
        .data_f2_i       (data_f2_i),
        .done_pre_data_i (done_pre_data_i),
        .status_nibble_i (status_nibble_i),
        .nibble_o        (nibble_o),
        .nibble_valid_o  (nibble_valid_o),
        .nibble_ready_i  (nibble_ready_i),
        .frame_start_o   (frame_start_o),
        .frame_last_o    (frame_last_o),
        .busy_o          (busy_o),
        .frame_drop_o    (frame_drop_o),
        .fsm_state_o     (fsm_state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_tx = 1'b0;
        forever #5 clk_tx = ~clk_tx;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [5:0]  exp_q[$];   // {start, last, nibble}
    logic [63:0] rise_q[$];  // expected valid-rise edge times
    logic        model_busy = 1'b0;
    logic        exp_drop = 1'b0;
    int          ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] mul_x4(input logic [3:0] v);
        logic [4:0] t;
        t = {1'b0, v};
        repeat (4) begin
            t = t << 1;
            if (t[4]) t = t ^ 5'h1D;
        end
        return t[3:0];
    endfunction

    task automatic push_frame(input logic [2:0] fmt, input logic [15:0] f1,
                              input logic [11:0] f2, input logic [3:0] st);
        logic [23:0] w;
        logic [3:0]  crc;
        logic [3:0]  nib;
        int          n;
        int          k;
        if (fmt == 3'b001) begin
            w = {f1[11:0], f2[3:0], f2[7:4], f2[11:8]};
            n = 6;
        end else if (fmt == 3'b110) begin
            w = {f1[13:0], f2[9:0]};
            n = 6;
        end else if (fmt == 3'b111) begin
            w = {f1, f2[7:0]};
            n = 6;
        end else begin
            w = {f1[11:0], 12'h000};
            n = 3;
        end
        exp_q.push_back({1'b1, 1'b0, st});
        crc = 4'h5;
        for (int i = 0; i < n; i++) begin
            nib = w[23 - 4*i -: 4];
            exp_q.push_back({1'b0, 1'b0, nib});
            crc = mul_x4(crc) ^ nib;
        end
        k = n;
`ifdef SENT_TX_CRC_RECOMMENDED_EN
        crc = mul_x4(crc);
        k = n + 1;
`endif
        exp_q.push_back({1'b0, 1'b1, crc});
        rise_q.push_back(64'($time) + 64'((k + 1) * 10));
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock edge, applying the model to any payload pulse present at that edge.
    task automatic tick();
        @(posedge clk_tx);
        exp_drop = 1'b0;
        if (reset_n_tx && done_pre_data_i && load_bit_i != 3'b000) begin
            if (!model_busy) begin
                push_frame(load_bit_i, data_f1_i, data_f2_i, status_nibble_i);
                model_busy = 1'b1;
            end else begin
                exp_drop = 1'b1;
            end
        end
        #2;
        done_pre_data_i = 1'b0;
        data_f1_i       = 16'($urandom);
        data_f2_i       = 12'($urandom);
        status_nibble_i = 4'($urandom);
        load_bit_i      = 3'($urandom);
    endtask

    task automatic drive_pulse(input logic [2:0] fmt, input logic [15:0] f1,
                               input logic [11:0] f2, input logic [3:0] st);
        load_bit_i      = fmt;
        data_f1_i       = f1;
        data_f2_i       = f2;
        status_nibble_i = st;
        done_pre_data_i = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && (exp_q.size() != 0 || model_busy); i++) tick();
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_send_data(input int limit);
        int i;
        for (i = 0; i < limit && !(nibble_valid_o && !frame_start_o && !frame_last_o); i++) tick();
        check("reach_send_data", 64'(i < limit), 64'd1);
    endtask

    always begin
        @(posedge clk_tx);
        #2;
        case (ready_mode)
            0:       nibble_ready_i = 1'b1;
            1:       nibble_ready_i = ~nibble_ready_i;
            default: nibble_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- monitor ----------------
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_last_xfer = 1'b0;
    logic [5:0] prev_out = 6'h0;
    logic [5:0] exp_item;

    always @(negedge clk_tx) begin
        if (!reset_n_tx) begin
            prev_valid     = 1'b0;
            prev_ready     = 1'b0;
            prev_last_xfer = 1'b0;
        end else begin
            if (exp_drop || frame_drop_o) check("frame_drop", 64'(frame_drop_o), 64'(exp_drop));
            check("busy", 64'(busy_o), 64'(model_busy));
            if (nibble_valid_o && !prev_valid) begin
                if (rise_q.size() == 0) check("unexpected_valid", 64'(nibble_valid_o), 64'd0);
                else check("valid_rise_time", 64'($time), rise_q.pop_front() + 64'd5);
            end
            if (!nibble_valid_o && prev_valid && !prev_last_xfer)
                check("valid_gap", 64'(nibble_valid_o), 64'd1);
            if (prev_valid && !prev_ready && nibble_valid_o)
                check("stall_stable", 64'({frame_start_o, frame_last_o, nibble_o}), 64'(prev_out));
            if (nibble_valid_o && nibble_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_nibble", 64'(nibble_valid_o), 64'd0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("nibble", 64'({frame_start_o, frame_last_o, nibble_o}), 64'(exp_item));
                    if (exp_item[4]) model_busy = 1'b0;
                end
            end
            prev_valid     = nibble_valid_o;
            prev_ready     = nibble_ready_i;
            prev_out       = {frame_start_o, frame_last_o, nibble_o};
            prev_last_xfer = nibble_valid_o && nibble_ready_i && frame_last_o;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n_tx      = 1'b0;
        load_bit_i      = 3'b000;
        data_f1_i       = 16'h0;
        data_f2_i       = 12'h0;
        done_pre_data_i = 1'b0;
        status_nibble_i = 4'h0;
        nibble_ready_i  = 1'b0;
        #1;
        check("rst_valid", 64'(nibble_valid_o), 64'd0);
        check("rst_nibble", 64'(nibble_o), 64'd0);
        check("rst_start", 64'(frame_start_o), 64'd0);
        check("rst_last", 64'(frame_last_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_drop", 64'(frame_drop_o), 64'd0);
        check("rst_state", 64'(fsm_state_o), 64'd0);
        repeat (3) tick();
        reset_n_tx = 1'b1;
        repeat (2) tick();

        // Format 010, all zero payload, ready held high.
        ready_mode = 0;
        drive_pulse(3'b010, 16'h0000, 12'h000, 4'h0);
        wait_drain(200);

        // Format 001, F2 sent least-significant nibble first.
        drive_pulse(3'b001, 16'h0123, 12'h456, 4'hA);
        wait_drain(200);

        // Format 111 with ready toggling every cycle.
        ready_mode = 1;
        drive_pulse(3'b111, 16'hBEEF, 12'h012, 4'($urandom));
        wait_drain(300);

        // Drop during SEND_DATA, then a capture on the CRC-accept edge.
        ready_mode = 0;
        repeat (2) tick();
        drive_pulse(3'b110, 16'($urandom), 12'($urandom), 4'($urandom));
        wait_send_data(100);
        drive_pulse(3'b011, 16'($urandom), 12'($urandom), 4'($urandom));
        begin
            int i;
            for (i = 0; i < 100 && !frame_last_o; i++) tick();
            check("reach_send_crc", 64'(i < 100), 64'd1);
        end
        drive_pulse(3'b001, 16'($urandom), 12'($urandom), 4'($urandom));
        wait_drain(300);

        // Format 000 pulse is ignored entirely.
        drive_pulse(3'b000, 16'hFFFF, 12'hFFF, 4'hF);
        repeat (20) tick();
        check("fmt000_no_valid", 64'(nibble_valid_o), 64'd0);
        check("fmt000_idle", 64'(fsm_state_o), 64'd0);

        // Randomized traffic: random formats, pulse spacing and ready pattern.
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 14)) tick();
            drive_pulse(3'($urandom_range(0, 7)), 16'($urandom), 12'($urandom), 4'($urandom));
        end
        wait_drain(1000);

        // Asynchronous reset in the middle of SEND_DATA.
        ready_mode = 1;
        drive_pulse(3'b111, 16'($urandom), 12'($urandom), 4'($urandom));
        wait_send_data(100);
        #1;
        reset_n_tx = 1'b0;
        #1;
        check("midrst_valid", 64'(nibble_valid_o), 64'd0);
        check("midrst_nibble", 64'(nibble_o), 64'd0);
        check("midrst_start_last", 64'({frame_start_o, frame_last_o}), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_state", 64'(fsm_state_o), 64'd0);
        exp_q.delete();
        rise_q.delete();
        model_busy = 1'b0;
        exp_drop   = 1'b0;
        repeat (3) tick();
        reset_n_tx = 1'b1;
        repeat (15) tick();
        check("postrst_valid", 64'(nibble_valid_o), 64'd0);
        check("postrst_state", 64'(fsm_state_o), 64'd0);

        // A clean frame after reset release.
        ready_mode = 2;
        drive_pulse(3'b101, 16'($urandom), 12'($urandom), 4'($urandom));
        wait_drain(300);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
